// File: rtl/scope_capture.sv
// Single-channel acquisition engine: circular sample RAM, level/slope trigger,
// frozen pre/post-trigger record served by screen column with one-cycle latency.
module scope_capture #(
    parameter int unsigned DATA_W       = 10,
    parameter int unsigned DEPTH        = 640,
    parameter int unsigned PRE          = 320,
    parameter int unsigned AUTO_TIMEOUT = 2**20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sample_valid,
    input  logic [DATA_W-1:0] i_sample,
    input  logic [DATA_W-1:0] i_level,
    input  logic              i_slope,
    input  logic [1:0]        i_mode,
    input  logic              i_arm,
    input  logic              i_frame_done,
    input  logic [9:0]        i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_frame_ready,
    output logic              o_triggered,
    output logic [2:0]        o_state
);

    localparam int unsigned AW     = 10;
    localparam int unsigned PW     = 11;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned TMR_W  = $clog2(AUTO_TIMEOUT + 1);
    localparam int unsigned POST_N = DEPTH - PRE - 1;

    localparam logic [PW-1:0]    DEPTH_P   = PW'(DEPTH);
    localparam logic [PW-1:0]    PRE_P     = PW'(PRE);
    localparam logic [AW-1:0]    PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_N - 1);
    localparam logic [TMR_W-1:0] TMO       = TMR_W'(AUTO_TIMEOUT);

    typedef enum logic [2:0] {
        S_PRE  = 3'd0,
        S_WAIT = 3'd1,
        S_POST = 3'd2,
        S_HOLD = 3'd3,
        S_STOP = 3'd4
    } state_t;

    state_t             r_state;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_start;
    logic [CNT_W-1:0]   r_cnt;
    logic [TMR_W-1:0]   r_timer;
    logic [DATA_W-1:0]  r_prev;
    logic               r_prev_ok;
    logic               r_triggered;
    logic               r_frame_ready;
    logic [DATA_W-1:0]  r_rd_data;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_capturing;
    logic               w_wr_en;
    logic               w_edge;
    logic               w_forced;
    logic               w_trig;
    logic [AW-1:0]      w_wr_next;
    logic [PW-1:0]      w_start_sum;
    logic [PW-1:0]      w_start;
    logic [PW-1:0]      w_rd_sum;
    logic [PW-1:0]      w_rd_idx;
    logic               w_rd_oob;

    assign w_capturing = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
    assign w_wr_en     = i_sample_valid && w_capturing && !i_arm;
    assign w_wr_next   = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + AW'(1);

    // Edge needs a previous valid sample in this capture to compare against
    assign w_edge = r_prev_ok && (i_slope ? ((r_prev >= i_level) && (i_sample <  i_level))
                                          : ((r_prev <  i_level) && (i_sample >= i_level)));
    assign w_forced = (i_mode == 2'b00) && (r_timer == TMO);
    assign w_trig   = w_wr_en && (r_state == S_WAIT) && (w_edge || w_forced);

    // Record start lies PRE samples behind the trigger sample, modulo DEPTH
    assign w_start_sum = PW'(r_wr_ptr) + DEPTH_P - PRE_P;
    assign w_start     = (w_start_sum >= DEPTH_P) ? w_start_sum - DEPTH_P : w_start_sum;

    assign w_rd_sum = PW'(r_start) + PW'(i_rd_addr);
    assign w_rd_idx = (w_rd_sum >= DEPTH_P) ? w_rd_sum - DEPTH_P : w_rd_sum;
    assign w_rd_oob = PW'(i_rd_addr) >= DEPTH_P;

    // Sample RAM: contents are not reset
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_sample;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_PRE;
            r_wr_ptr      <= '0;
            r_start       <= '0;
            r_cnt         <= '0;
            r_timer       <= '0;
            r_prev        <= '0;
            r_prev_ok     <= 1'b0;
            r_triggered   <= 1'b0;
            r_frame_ready <= 1'b0;
            r_rd_data     <= '0;
        end else begin
            r_rd_data <= w_rd_oob ? '0 : r_mem[w_rd_idx[AW-1:0]];
            if (i_sample_valid) begin
                r_prev <= i_sample;
            end
            if (i_arm) begin
                r_state       <= S_PRE;
                r_wr_ptr      <= '0;
                r_cnt         <= '0;
                r_timer       <= '0;
                r_prev_ok     <= 1'b0;
                r_frame_ready <= 1'b0;
            end else begin
                if (i_sample_valid) begin
                    r_prev_ok <= 1'b1;
                end
                if (w_wr_en) begin
                    r_wr_ptr <= w_wr_next;
                end
                case (r_state)
                    S_PRE: begin
                        if (i_sample_valid) begin
                            if (r_cnt == PRE_LAST) begin
                                r_state <= S_WAIT;
                                r_cnt   <= '0;
                                r_timer <= '0;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_WAIT: begin
                        if (w_trig) begin
                            r_start     <= w_start[AW-1:0];
                            r_triggered <= w_edge;
                            r_cnt       <= '0;
                            if (POST_N == 0) begin
                                r_state       <= S_HOLD;
                                r_frame_ready <= 1'b1;
                            end else begin
                                r_state <= S_POST;
                            end
                        end else if (r_timer != TMO) begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    S_POST: begin
                        if (i_sample_valid) begin
                            if (r_cnt == POST_LAST) begin
                                r_state       <= S_HOLD;
                                r_frame_ready <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_HOLD: begin
                        if (i_frame_done) begin
                            if (i_mode == 2'b10) begin
                                r_state <= S_STOP;
                            end else begin
                                r_state       <= S_PRE;
                                r_frame_ready <= 1'b0;
                                r_prev_ok     <= 1'b0;
                                r_cnt         <= '0;
                            end
                        end
                    end
                    S_STOP: begin
                        r_state <= S_STOP;
                    end
                    default: begin
                        r_state <= S_PRE;
                    end
                endcase
            end
        end
    end

    assign o_rd_data     = r_rd_data;
    assign o_frame_ready = r_frame_ready;
    assign o_triggered   = r_triggered;
    assign o_state       = r_state;

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: edges, auto timeout, single shot,
// record wrap-around, arm priority and asynchronous reset.
module tb_scope_capture;

    localparam int unsigned DATA_W       = 10;
    localparam int unsigned DEPTH        = 640;
    localparam int unsigned PRE          = 320;
    localparam int unsigned AUTO_TIMEOUT = 1000;

    logic              clk;
    logic              rst_n;
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] level;
    logic              slope;
    logic [1:0]        mode;
    logic              arm;
    logic              frame_done;
    logic [9:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              frame_ready;
    logic              triggered;
    logic [2:0]        state;

    int errors = 0;
    int checks = 0;

    scope_capture #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .PRE         (PRE),
        .AUTO_TIMEOUT(AUTO_TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sample_valid(sample_valid),
        .i_sample      (sample),
        .i_level       (level),
        .i_slope       (slope),
        .i_mode        (mode),
        .i_arm         (arm),
        .i_frame_done  (frame_done),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_frame_ready (frame_ready),
        .o_triggered   (triggered),
        .o_state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern 0 ramp step 4, 1 square 900/100 per 400, 2 constant 50, 3 wrap-trigger stream
    function automatic logic [DATA_W-1:0] gen(input int pat, input int k);
        case (pat)
            0:       return DATA_W'((k * 4) % 1024);
            1:       return (((k / 400) % 2) == 0) ? 10'd900 : 10'd100;
            2:       return 10'd50;
            3:       return (k < 740) ? DATA_W'(k % 500) : DATA_W'(512 + k - 740);
            default: return '0;
        endcase
    endfunction

    task automatic pulse_arm();
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic pulse_frame_done();
        frame_done = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
    endtask

    task automatic feed(input int pat, input int k0, input int n);
        for (int i = 0; i < n; i++) begin
            sample       = gen(pat, k0 + i);
            sample_valid = 1'b1;
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
    endtask

    task automatic run_capture(input int pat, input int budget, output int cycles, output bit ok);
        int k;
        k      = 0;
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget) begin
            sample       = gen(pat, k);
            sample_valid = 1'b1;
            k++;
            @(posedge clk);
            cycles++;
            #1;
            if (state == 3'd3) begin
                ok = 1'b1;
                break;
            end
        end
        sample_valid = 1'b0;
    endtask

    task automatic read_rec(input int a, output logic [DATA_W-1:0] d);
        rd_addr = 10'(a);
        @(posedge clk); #1;
        d = rd_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sample_valid = 1'b0; sample = '0; level = 10'd512; slope = 1'b0;
        mode = 2'b01; arm = 1'b0; frame_done = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0d expected 0", frame_ready); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL reset_trig: got %0d expected 0", triggered); end
        checks++; if (rd_data !== 10'd0) begin errors++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rising();
        int cyc; bit ok; logic [DATA_W-1:0] d;
        level = 10'd512; slope = 1'b0; mode = 2'b01;
        pulse_arm();
        run_capture(0, 2000, cyc, ok);
        checks++; if (!ok || cyc != 704) begin errors++; $display("FAIL rise_hold_cycles: got %0d (reached=%0d) expected 704", cyc, ok); end
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL rise_trig: got %0d expected 1", triggered); end
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL rise_ready: got %0d expected 1", frame_ready); end
        read_rec(320, d);
        checks++; if (d !== 10'd512) begin errors++; $display("FAIL rise_rd320: got %0d expected 512", d); end
        read_rec(319, d);
        checks++; if (d !== 10'd508) begin errors++; $display("FAIL rise_rd319: got %0d expected 508", d); end
        read_rec(321, d);
        checks++; if (d !== 10'd516) begin errors++; $display("FAIL rise_rd321: got %0d expected 516", d); end
        read_rec(0, d);
        checks++; if (d !== 10'd256) begin errors++; $display("FAIL rise_rd0: got %0d expected 256", d); end
        read_rec(639, d);
        checks++; if (d !== 10'd764) begin errors++; $display("FAIL rise_rd639: got %0d expected 764", d); end
    endtask

    task automatic test_falling();
        int cyc; bit ok; logic [DATA_W-1:0] d;
        level = 10'd512; slope = 1'b1; mode = 2'b01;
        pulse_arm();
        run_capture(1, 2000, cyc, ok);
        checks++; if (!ok || cyc != 720) begin errors++; $display("FAIL fall_hold_cycles: got %0d (reached=%0d) expected 720", cyc, ok); end
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL fall_trig: got %0d expected 1", triggered); end
        read_rec(320, d);
        checks++; if (d !== 10'd100) begin errors++; $display("FAIL fall_rd320: got %0d expected 100", d); end
        read_rec(319, d);
        checks++; if (d !== 10'd900) begin errors++; $display("FAIL fall_rd319: got %0d expected 900", d); end
        read_rec(0, d);
        checks++; if (d !== 10'd900) begin errors++; $display("FAIL fall_rd0: got %0d expected 900", d); end
        read_rec(639, d);
        checks++; if (d !== 10'd100) begin errors++; $display("FAIL fall_rd639: got %0d expected 100", d); end
    endtask

    task automatic test_auto();
        int cyc; bit ok;
        level = 10'd512; slope = 1'b0; mode = 2'b00;
        pulse_arm();
        run_capture(2, 3000, cyc, ok);
        checks++; if (!ok || cyc != 1640) begin errors++; $display("FAIL auto_hold_cycles: got %0d (reached=%0d) expected 1640", cyc, ok); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL auto_trig: got %0d expected 0", triggered); end
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL auto_ready: got %0d expected 1", frame_ready); end
        mode = 2'b01;
        pulse_arm();
        feed(2, 0, 2000);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL normal_stays_wait: got %0d expected 1", state); end
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL normal_no_ready: got %0d expected 0", frame_ready); end
    endtask

    task automatic test_single();
        int cyc; bit ok; logic [DATA_W-1:0] d;
        level = 10'd512; slope = 1'b0; mode = 2'b10;
        pulse_arm();
        run_capture(0, 2000, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_hold: got %0d expected 1", ok); end
        pulse_frame_done();
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL single_stop_state: got %0d expected 4", state); end
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL single_stop_ready: got %0d expected 1", frame_ready); end
        feed(2, 0, 50);
        read_rec(320, d);
        checks++; if (d !== 10'd512) begin errors++; $display("FAIL single_frozen320: got %0d expected 512", d); end
        read_rec(0, d);
        checks++; if (d !== 10'd256) begin errors++; $display("FAIL single_frozen0: got %0d expected 256", d); end
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL single_still_stop: got %0d expected 4", state); end
        pulse_arm();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL single_arm_state: got %0d expected 0", state); end
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL single_arm_ready: got %0d expected 0", frame_ready); end
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL single_arm_trig_kept: got %0d expected 1", triggered); end
    endtask

    task automatic test_wrap();
        int cyc; bit ok; logic [DATA_W-1:0] d;
        level = 10'd512; slope = 1'b0; mode = 2'b01;
        pulse_arm();
        run_capture(3, 2000, cyc, ok);
        checks++; if (!ok || cyc != 1060) begin errors++; $display("FAIL wrap_hold_cycles: got %0d (reached=%0d) expected 1060", cyc, ok); end
        read_rec(219, d);
        checks++; if (d !== 10'd139) begin errors++; $display("FAIL wrap_rd219: got %0d expected 139", d); end
        read_rec(220, d);
        checks++; if (d !== 10'd140) begin errors++; $display("FAIL wrap_rd220: got %0d expected 140", d); end
        read_rec(320, d);
        checks++; if (d !== 10'd512) begin errors++; $display("FAIL wrap_rd320: got %0d expected 512", d); end
        read_rec(319, d);
        checks++; if (d !== 10'd239) begin errors++; $display("FAIL wrap_rd319: got %0d expected 239", d); end
        read_rec(700, d);
        checks++; if (d !== 10'd0) begin errors++; $display("FAIL wrap_rd700: got %0d expected 0", d); end
    endtask

    task automatic test_priority();
        level = 10'd512; slope = 1'b0; mode = 2'b01;
        pulse_arm();
        feed(2, 0, 330);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL prio_in_wait: got %0d expected 1", state); end
        sample = 10'd600; sample_valid = 1'b1; arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0; sample_valid = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL prio_arm_over_edge: got %0d expected 0", state); end
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL prio_ready: got %0d expected 0", frame_ready); end
    endtask

    task automatic test_reset_mid();
        int cyc; bit ok;
        level = 10'd512; slope = 1'b0; mode = 2'b01; rd_addr = 10'd5;
        pulse_arm();
        feed(0, 0, 385);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL post_after_trigger: got %0d expected 2", state); end
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL post_trig: got %0d expected 1", triggered); end
        feed(0, 385, 5);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rstmid_state: got %0d expected 0", state); end
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %0d expected 0", frame_ready); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL rstmid_trig: got %0d expected 0", triggered); end
        checks++; if (rd_data !== 10'd0) begin errors++; $display("FAIL rstmid_rd_data: got %0d expected 0", rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rstmid_restart_pre: got %0d expected 0", state); end
        run_capture(0, 2000, cyc, ok);
        checks++; if (!ok || cyc != 704) begin errors++; $display("FAIL rstmid_recapture: got %0d (reached=%0d) expected 704", cyc, ok); end
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL rstmid_recap_trig: got %0d expected 1", triggered); end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling();
        test_auto();
        test_single();
        test_wrap();
        test_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
